// File: rtl/vga_timing.sv
// Raster timing generator for the 800x600@60 Hz display path: pixel coordinates,
// sync pulses, active-video flag and per-line / per-frame strobes.
module vga_timing #(
  parameter int   H_VISIBLE = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_VISIBLE = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic SYNC_POL  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [10:0] hcnt, hcnt_nxt;
  logic [9:0]  vcnt, vcnt_nxt;
  logic        h_wrap, v_wrap;
  logic        h_vis_nxt, v_vis_nxt;
  logic        active_r;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    h_wrap   = (hcnt == H_LAST);
    v_wrap   = (vcnt == V_LAST);
    hcnt_nxt = hcnt + 11'd1;
    vcnt_nxt = vcnt;
    if (h_wrap) begin
      hcnt_nxt = '0;
      vcnt_nxt = v_wrap ? '0 : vcnt + 10'd1;
    end
    h_vis_nxt = (hcnt_nxt < H_VIS);
    v_vis_nxt = (vcnt_nxt < V_VIS);
  end

  // Outputs are decoded from the next counter value so they line up with the
  // counters they describe, with no pipeline lag.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      X          <= '0;
      Y          <= '0;
      active_r   <= 1'b1;  // decode of (0,0); masked while reset is held
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else if (pix_en) begin
      hcnt       <= hcnt_nxt;
      vcnt       <= vcnt_nxt;
      X          <= h_vis_nxt ? hcnt_nxt[9:0] : '0;
      Y          <= v_vis_nxt ? vcnt_nxt : '0;
      active_r   <= h_vis_nxt && v_vis_nxt;
      hsync      <= (hcnt_nxt >= HS_START && hcnt_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync      <= (vcnt_nxt >= VS_START && vcnt_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
      line_tick  <= h_wrap;
      frame_tick <= h_wrap && v_wrap;
    end else begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end
  end

  // Blank while reset is held; on release the (0,0) decode shows immediately.
  assign active = active_r && !reset;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: full-size instance for line-level timing,
// a shrunken inverted-polarity instance for frame-level timing.
module tb_vga_timing;

  // Small instance geometry: 25 clocks per line, 10 lines per frame.
  localparam int S_HV = 16, S_HFP = 2, S_HS = 4, S_HBP = 3;
  localparam int S_VV = 6,  S_VFP = 1, S_VS = 2, S_VBP = 1;
  localparam int S_HT = S_HV + S_HFP + S_HS + S_HBP;
  localparam int S_VT = S_VV + S_VFP + S_VS + S_VBP;
  localparam int B_HT = 1056;
  localparam int B_VT = 628;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       lt;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic [9:0] b_x, b_y, s_x, s_y;
  logic       b_active, b_hsync, b_vsync, b_lt, b_ft;
  logic       s_active, s_hsync, s_vsync, s_lt, s_ft;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vga_timing dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .X(b_x), .Y(b_y), .active(b_active), .hsync(b_hsync), .vsync(b_vsync),
    .line_tick(b_lt), .frame_tick(b_ft)
  );

  vga_timing #(
    .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .X(s_x), .Y(s_y), .active(s_active), .hsync(s_hsync), .vsync(s_vsync),
    .line_tick(s_lt), .frame_tick(s_ft)
  );

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Model: n = number of pixel advances since reset; position follows by division.
  int   b_n = 0, s_n = 0;
  logic b_mlt = 0, b_mft = 0, s_mlt = 0, s_mft = 0;
  logic started = 0;

  always @(posedge clk) begin
    if (reset) begin
      b_n <= 0; s_n <= 0;
      b_mlt <= 0; b_mft <= 0; s_mlt <= 0; s_mft <= 0;
      started <= 1'b1;
    end else if (pix_en) begin
      b_n   <= b_n + 1;
      s_n   <= s_n + 1;
      b_mlt <= ((b_n + 1) % B_HT == 0);
      b_mft <= ((b_n + 1) % (B_HT * B_VT) == 0);
      s_mlt <= ((s_n + 1) % S_HT == 0);
      s_mft <= ((s_n + 1) % (S_HT * S_VT) == 0);
    end else begin
      b_mlt <= 0; b_mft <= 0; s_mlt <= 0; s_mft <= 0;
    end
  end

  function automatic exp_t calc(input int n, input logic rst, input logic lt, input logic ft,
                                input int hv, input int hfp, input int hs, input int hbp,
                                input int vv, input int vfp, input int vs, input int vbp,
                                input logic pol);
    exp_t e;
    int ht = hv + hfp + hs + hbp;
    int vt = vv + vfp + vs + vbp;
    int h  = n % ht;
    int v  = (n / ht) % vt;
    e.x      = (h < hv) ? 10'(h) : 10'd0;
    e.y      = (v < vv) ? 10'(v) : 10'd0;
    e.active = !rst && (h < hv) && (v < vv);
    e.hsync  = (h >= hv + hfp && h < hv + hfp + hs) ? pol : ~pol;
    e.vsync  = (v >= vv + vfp && v < vv + vfp + vs) ? pol : ~pol;
    e.lt     = lt;
    e.ft     = ft;
    return e;
  endfunction

  // Per-cycle comparison of both instances against the model, away from the edge.
  always @(negedge clk) begin
    if (started) begin
      exp_t eb, es;
      eb = calc(b_n, reset, b_mlt, b_mft, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1);
      es = calc(s_n, reset, s_mlt, s_mft, S_HV, S_HFP, S_HS, S_HBP,
                S_VV, S_VFP, S_VS, S_VBP, 1'b0);
      check("b_X",          b_x,      eb.x);
      check("b_Y",          b_y,      eb.y);
      check("b_active",     b_active, eb.active);
      check("b_hsync",      b_hsync,  eb.hsync);
      check("b_vsync",      b_vsync,  eb.vsync);
      check("b_line_tick",  b_lt,     eb.lt);
      check("b_frame_tick", b_ft,     eb.ft);
      check("s_X",          s_x,      es.x);
      check("s_Y",          s_y,      es.y);
      check("s_active",     s_active, es.active);
      check("s_hsync",      s_hsync,  es.hsync);
      check("s_vsync",      s_vsync,  es.vsync);
      check("s_line_tick",  s_lt,     es.lt);
      check("s_frame_tick", s_ft,     es.ft);
    end
  end

  initial begin
    int k;
    reset  = 1'b1;
    pix_en = 1'b1;  // reset must win over pix_en
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Literal expectations; each repeat(k) moves the advance count by k.
    @(negedge clk);                                   // n = 0
    check("lit_rel_active", b_active, 1);
    check("lit_rel_X",      b_x,      0);
    check("lit_rel_hsync",  b_hsync,  0);
    check("lit_rel_lt",     b_lt,     0);
    check("lit_rel_s_ft",   s_ft,     0);
    repeat (174) @(negedge clk);                      // n = 174: small v=6
    check("lit_s_vsync_174", s_vsync, 1);
    repeat (1) @(negedge clk);                        // n = 175: small v=7
    check("lit_s_vsync_175", s_vsync, 0);
    repeat (50) @(negedge clk);                       // n = 225: small v=9
    check("lit_s_vsync_225", s_vsync, 1);
    repeat (25) @(negedge clk);                       // n = 250: small frame wrap
    check("lit_s_ft_250",     s_ft,     1);
    check("lit_s_lt_250",     s_lt,     1);
    check("lit_s_active_250", s_active, 1);
    check("lit_b_X_250",      b_x,      250);
    repeat (549) @(negedge clk);                      // n = 799
    check("lit_b_X_799",      b_x,      799);
    check("lit_b_active_799", b_active, 1);
    repeat (1) @(negedge clk);                        // n = 800
    check("lit_b_X_800",      b_x,      0);
    check("lit_b_active_800", b_active, 0);
    repeat (39) @(negedge clk);                       // n = 839
    check("lit_b_hsync_839",  b_hsync,  0);
    repeat (1) @(negedge clk);                        // n = 840
    check("lit_b_hsync_840",  b_hsync,  1);
    repeat (127) @(negedge clk);                      // n = 967
    check("lit_b_hsync_967",  b_hsync,  1);
    repeat (1) @(negedge clk);                        // n = 968
    check("lit_b_hsync_968",  b_hsync,  0);
    repeat (88) @(negedge clk);                       // n = 1056
    check("lit_b_lt_1056",     b_lt,     1);
    check("lit_b_Y_1056",      b_y,      1);
    check("lit_b_X_1056",      b_x,      0);
    check("lit_b_active_1056", b_active, 1);
    check("lit_b_ft_1056",     b_ft,     0);

    // Free run, then 50 % pixel enable.
    repeat (1200) @(posedge clk);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #2 pix_en = ~pix_en;
    end
    pix_en = 1'b1;

    // Mid-line reset at hcnt = 500 of the full-size instance.
    for (k = 0; k < 3000 && (b_n % B_HT) != 500; k++) begin
      @(posedge clk);
      #2;
    end
    check("seek_hcnt_500_in_budget", int'(k < 3000), 1);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("lit_rst2_X",      b_x,      0);
    check("lit_rst2_Y",      b_y,      0);
    check("lit_rst2_active", b_active, 1);
    check("lit_rst2_s_ft",   s_ft,     0);
    repeat (1100) @(posedge clk);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
